// File: rtl/opf_pkg.sv
// Shared widths, FSM state encoding and the held-request record for operand_fetch.
package opf_pkg;

    localparam int DATA_W = 8;
    localparam int NREGS  = 8;
    localparam int ADDR_W = $clog2(NREGS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STALL = 2'd1,
        VALID = 2'd2
    } opf_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] rs1;
        logic [ADDR_W-1:0] rs2;
        logic [ADDR_W-1:0] rd;
        logic              rd_we;
    } req_t;

endpackage

// File: rtl/operand_fetch_if.sv
// Decoder-to-fetch request channel and fetch-to-ALU operand channel, both valid/ready.
// master = upstream/downstream environment view, slave = operand_fetch view.
interface operand_fetch_if
    import opf_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int AW = ADDR_W
);
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_rs1;
    logic [AW-1:0] req_rs2;
    logic [AW-1:0] req_rd;
    logic          req_rd_we;

    logic          op_valid;
    logic          op_ready;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic [AW-1:0] op_rd;
    logic          op_rd_we;

    modport master (
        output req_valid, req_rs1, req_rs2, req_rd, req_rd_we, op_ready,
        input  req_ready, op_valid, op_a, op_b, op_rd, op_rd_we
    );

    modport slave (
        input  req_valid, req_rs1, req_rs2, req_rd, req_rd_we, op_ready,
        output req_ready, op_valid, op_a, op_b, op_rd, op_rd_we
    );
endinterface

// File: rtl/opf_scoreboard.sv
// Purpose: per-register busy bits marking write-backs still in flight.
// Latency: set/clear take effect at the edge; lookups are combinational.
// Backpressure: none; a set and a clear of the same index in one cycle leave it busy.
module opf_scoreboard
    import opf_pkg::*;
#(
    parameter int NR = NREGS,
    parameter int AW = ADDR_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          set_en,
    input  logic [AW-1:0] set_addr,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_addr,
    input  logic [AW-1:0] look_a,
    input  logic [AW-1:0] look_b,
    output logic          busy_a,
    output logic          busy_b
);
    logic [NR-1:0] busy;
    logic [NR-1:0] busy_nxt;

    // Clear first so a same-index set overrides it.
    always_comb begin
        busy_nxt = busy;
        if (clr_en) busy_nxt[clr_addr] = 1'b0;
        if (set_en) busy_nxt[set_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) busy <= '0;
        else        busy <= busy_nxt;
    end

    assign busy_a = busy[look_a];
    assign busy_b = busy[look_b];
endmodule

// File: rtl/operand_fetch.sv
// Purpose: pick two register-file operands for the ALU, stalling on pending write-backs.
// Latency: 1 cycle from accepted request to op_valid; OPF_BYPASS_EN forwards wb_data and drops the stall bubble.
// Backpressure: req_ready low while stalled or while held operands wait on op_ready.
module operand_fetch
    import opf_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int NR = NREGS,
    parameter int AW = ADDR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NR*DW-1:0] rf_data,
    input  logic             wb_valid,
    input  logic [AW-1:0]    wb_addr,
    input  logic [DW-1:0]    wb_data,
    operand_fetch_if.slave   bus
);
    opf_state_t    state;
    req_t          held;
    req_t          req_in;
    req_t          src;
    logic [DW-1:0] rf_word [NR];
    logic [DW-1:0] val_a, val_b;
    logic          busy_a, busy_b;
    logic          hazard, accept, load, free;

    logic          op_valid;
    logic [DW-1:0] op_a, op_b;
    logic [AW-1:0] op_rd;
    logic          op_rd_we;

    always_comb begin
        for (int i = 0; i < NR; i++) rf_word[i] = rf_data[i*DW +: DW];
    end

    assign req_in = '{rs1: bus.req_rs1, rs2: bus.req_rs2, rd: bus.req_rd, rd_we: bus.req_rd_we};
    // While stalled the hazard check runs on the held request, not the live bus.
    assign src    = (state == STALL) ? held : req_in;

    opf_scoreboard #(.NR(NR), .AW(AW)) u_sb (
        .clk      (clk),
        .reset    (reset),
        .set_en   (load && src.rd_we),
        .set_addr (src.rd),
        .clr_en   (wb_valid),
        .clr_addr (wb_addr),
        .look_a   (src.rs1),
        .look_b   (src.rs2),
        .busy_a   (busy_a),
        .busy_b   (busy_b)
    );

`ifdef OPF_BYPASS_EN
    logic fwd_a, fwd_b;
    assign fwd_a  = busy_a && wb_valid && (wb_addr == src.rs1);
    assign fwd_b  = busy_b && wb_valid && (wb_addr == src.rs2);
    assign hazard = (busy_a && !fwd_a) || (busy_b && !fwd_b);
    assign val_a  = fwd_a ? wb_data : rf_word[src.rs1];
    assign val_b  = fwd_b ? wb_data : rf_word[src.rs2];
`else
    logic unused_wb_data;
    assign unused_wb_data = ^wb_data;
    assign hazard = busy_a || busy_b;
    assign val_a  = rf_word[src.rs1];
    assign val_b  = rf_word[src.rs2];
`endif

    assign free          = !op_valid || bus.op_ready;
    assign bus.req_ready = (state != STALL) && free;
    assign accept        = bus.req_valid && bus.req_ready;
    assign load          = (accept || (state == STALL)) && !hazard;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            held     <= '0;
            op_valid <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            op_rd    <= '0;
            op_rd_we <= 1'b0;
        end else if (load) begin
            state    <= VALID;
            op_valid <= 1'b1;
            op_a     <= val_a;
            op_b     <= val_b;
            op_rd    <= src.rd;
            op_rd_we <= src.rd_we;
        end else if (accept) begin
            state    <= STALL;
            held     <= req_in;
            op_valid <= 1'b0;
        end else if ((state == VALID) && bus.op_ready) begin
            state    <= IDLE;
            op_valid <= 1'b0;
        end
    end

    assign bus.op_valid = op_valid;
    assign bus.op_a     = op_a;
    assign bus.op_b     = op_b;
    assign bus.op_rd    = op_rd;
    assign bus.op_rd_we = op_rd_we;
endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a small register-file model; honours OPF_BYPASS_EN.
module tb_operand_fetch;
    logic        clk;
    logic        reset;
    logic        wb_valid;
    logic [2:0]  wb_addr;
    logic [7:0]  wb_data;
    logic [63:0] rf_data;
    logic [7:0]  rf [8];

    int passed = 0;
    int total  = 0;

    operand_fetch_if bus ();

    operand_fetch dut (
        .clk     (clk),
        .reset   (reset),
        .rf_data (rf_data),
        .wb_valid(wb_valid),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: known contents under reset, written by write-back at the edge.
    always @(posedge clk) begin
        if (!reset) begin
            rf[0] <= 8'h0F; rf[1] <= 8'h11; rf[2] <= 8'h22; rf[3] <= 8'h33;
            rf[4] <= 8'h44; rf[5] <= 8'h55; rf[6] <= 8'h66; rf[7] <= 8'h77;
        end else if (wb_valid) begin
            rf[wb_addr] <= wb_data;
        end
    end

    always_comb begin
        rf_data = '0;
        for (int i = 0; i < 8; i++) rf_data[i*8 +: 8] = rf[i];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic req(input logic v, input logic [2:0] rs1, input logic [2:0] rs2,
                       input logic [2:0] rd, input logic we);
        bus.req_valid = v;
        bus.req_rs1   = rs1;
        bus.req_rs2   = rs2;
        bus.req_rd    = rd;
        bus.req_rd_we = we;
    endtask

    task automatic wb(input logic v, input logic [2:0] a, input logic [7:0] d);
        wb_valid = v;
        wb_addr  = a;
        wb_data  = d;
    endtask

    initial begin
        reset = 1'b0;
        bus.op_ready = 1'b0;
        req(1'b0, 3'd0, 3'd0, 3'd0, 1'b0);
        wb(1'b0, 3'd0, 8'h00);

        // 1. reset
        tick();
        tick();
        chk("rst_op_valid", {31'd0, bus.op_valid}, 32'd0);
        chk("rst_op_a",     {24'd0, bus.op_a},     32'd0);
        chk("rst_op_b",     {24'd0, bus.op_b},     32'd0);
        chk("rst_op_rd",    {29'd0, bus.op_rd},    32'd0);
        chk("rst_op_rd_we", {31'd0, bus.op_rd_we}, 32'd0);
        reset = 1'b1;
        #1;
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);

        // 2. simple issue
        req(1'b1, 3'd1, 3'd2, 3'd3, 1'b1);
        tick();
        chk("iss_op_valid", {31'd0, bus.op_valid}, 32'd1);
        chk("iss_op_a",     {24'd0, bus.op_a},     32'h11);
        chk("iss_op_b",     {24'd0, bus.op_b},     32'h22);
        chk("iss_op_rd",    {29'd0, bus.op_rd},    32'd3);
        chk("iss_op_rd_we", {31'd0, bus.op_rd_we}, 32'd1);
        chk("iss_busy",     {24'd0, dut.u_sb.busy}, 32'h08);

        // 3. dependent request stalls until write-back of r3
        bus.op_ready = 1'b1;
        req(1'b1, 3'd3, 3'd0, 3'd5, 1'b0);
        #1;
        chk("dep_req_ready", {31'd0, bus.req_ready}, 32'd1);
        tick();
        bus.op_ready = 1'b0;
        req(1'b0, 3'd1, 3'd2, 3'd6, 1'b1);
        #1;
        chk("stall_req_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("stall_op_valid",  {31'd0, bus.op_valid},  32'd0);
        tick();
        chk("stall2_op_valid", {31'd0, bus.op_valid},  32'd0);
        wb(1'b1, 3'd3, 8'h5A);
        tick();
        wb(1'b0, 3'd0, 8'h00);
`ifdef OPF_BYPASS_EN
        chk("byp_op_valid", {31'd0, bus.op_valid}, 32'd1);
        chk("byp_op_a",     {24'd0, bus.op_a},     32'h5A);
`else
        chk("wbT_op_valid", {31'd0, bus.op_valid}, 32'd0);
        tick();
        chk("wbT1_op_valid", {31'd0, bus.op_valid}, 32'd1);
        chk("wbT1_op_a",     {24'd0, bus.op_a},     32'h5A);
`endif
        chk("dep_op_b",     {24'd0, bus.op_b},      32'h0F);
        chk("dep_op_rd",    {29'd0, bus.op_rd},     32'd5);
        chk("dep_op_rd_we", {31'd0, bus.op_rd_we},  32'd0);
        chk("dep_busy",     {24'd0, dut.u_sb.busy}, 32'h00);

        // 4. output backpressure, then back-to-back transfer
        req(1'b1, 3'd4, 3'd7, 3'd4, 1'b1);
        #1;
        chk("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_op_valid",  {31'd0, bus.op_valid},  32'd1);
            chk("bp_op_a",      {24'd0, bus.op_a},      32'h5A);
            chk("bp_op_b",      {24'd0, bus.op_b},      32'h0F);
            chk("bp_op_rd",     {29'd0, bus.op_rd},     32'd5);
            chk("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
        end
        bus.op_ready = 1'b1;
        #1;
        chk("b2b_req_ready", {31'd0, bus.req_ready}, 32'd1);
        tick();
        chk("b2b_op_valid", {31'd0, bus.op_valid},  32'd1);
        chk("b2b_op_a",     {24'd0, bus.op_a},      32'h44);
        chk("b2b_op_b",     {24'd0, bus.op_b},      32'h77);
        chk("b2b_op_rd",    {29'd0, bus.op_rd},     32'd4);
        chk("b2b_busy",     {24'd0, dut.u_sb.busy}, 32'h10);

        // 5. set and clear of busy[4] in one cycle, then wb to a non-busy register
        req(1'b1, 3'd1, 3'd2, 3'd4, 1'b1);
        wb(1'b1, 3'd4, 8'h99);
        #1;
        chk("sc_req_ready", {31'd0, bus.req_ready}, 32'd1);
        tick();
        chk("sc_op_a", {24'd0, bus.op_a},      32'h11);
        chk("sc_op_b", {24'd0, bus.op_b},      32'h22);
        chk("sc_busy", {24'd0, dut.u_sb.busy}, 32'h10);
        req(1'b0, 3'd0, 3'd0, 3'd0, 1'b0);
        wb(1'b1, 3'd6, 8'hA6);
        tick();
        chk("nb_busy",     {24'd0, dut.u_sb.busy}, 32'h10);
        chk("nb_op_valid", {31'd0, bus.op_valid},  32'd0);
        wb(1'b0, 3'd0, 8'h00);
        req(1'b1, 3'd6, 3'd6, 3'd0, 1'b0);
        tick();
        chk("same_op_valid", {31'd0, bus.op_valid}, 32'd1);
        chk("same_op_a",     {24'd0, bus.op_a},     32'hA6);
        chk("same_op_b",     {24'd0, bus.op_b},     32'hA6);

        // 6. reset while stalled drops the held request
        req(1'b1, 3'd2, 3'd4, 3'd7, 1'b1);
        tick();
        req(1'b0, 3'd0, 3'd0, 3'd0, 1'b0);
        #1;
        chk("rs_req_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("rs_op_valid",  {31'd0, bus.op_valid},  32'd0);
        reset = 1'b0;
        tick();
        chk("rs_rst_op_valid", {31'd0, bus.op_valid},  32'd0);
        chk("rs_rst_busy",     {24'd0, dut.u_sb.busy}, 32'h00);
        chk("rs_rst_op_a",     {24'd0, bus.op_a},      32'h00);
        chk("rs_rst_op_rd",    {29'd0, bus.op_rd},     32'd0);
        reset = 1'b1;
        tick();
        tick();
        chk("rs_post_op_valid",  {31'd0, bus.op_valid},  32'd0);
        chk("rs_post_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rs_post_busy",      {24'd0, dut.u_sb.busy}, 32'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
